// File: rtl/full_adder_pkg.sv
// Shared definitions for the ripple-carry full adder: width limit, carry-chain type,
// and a golden-sum helper for benches.
package full_adder_pkg;

    localparam int unsigned FA_MAX_WIDTH = 64;

    typedef logic [FA_MAX_WIDTH:0] fa_carry_t;

    // Result is always FA_MAX_WIDTH+1 bits; callers keep the low WIDTH+1 bits.
    function automatic fa_carry_t fa_ref(input logic [FA_MAX_WIDTH-1:0] a,
                                         input logic [FA_MAX_WIDTH-1:0] b,
                                         input logic                    cin);
        fa_carry_t r;
        r = {1'b0, a} + {1'b0, b} + {{FA_MAX_WIDTH{1'b0}}, cin};
        return r;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full-adder cell; the ripple chain is built from these.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/full_adder_unit.sv
// WIDTH-bit ripple-carry adder: {Cout, Sum} = A + B + Cin.
// Define FULL_ADDER_OUTPUT_REG_EN to register the outputs (1-cycle latency, async reset to 0).
module full_adder_unit
    import full_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_width_check
        $error("full_adder_unit: WIDTH=%0d outside 1..%0d", WIDTH, FA_MAX_WIDTH);
    end

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a  (A[i]),
            .b  (B[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

`ifdef FULL_ADDER_OUTPUT_REG_EN
    logic [WIDTH:0] res_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
        end else begin
            res_q <= {c[WIDTH], s};
        end
    end

    assign {Cout, Sum} = res_q;
`else
    // Clock and reset are part of the fixed interface but unused when combinational.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign {Cout, Sum} = {c[WIDTH], s};
`endif

endmodule

// File: tb/tb_full_adder_unit.sv
// Self-checking bench for full_adder_unit at WIDTH 1, 4, 8 and 32; follows the
// FULL_ADDER_OUTPUT_REG_EN build for latency and reset behaviour.
module tb_full_adder_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic [0:0]  a1,  b1;  logic [0:0]  s1;  logic cin1,  co1;
    logic [3:0]  a4,  b4;  logic [3:0]  s4;  logic cin4,  co4;
    logic [7:0]  a8,  b8;  logic [7:0]  s8;  logic cin8,  co8;
    logic [31:0] a32, b32; logic [31:0] s32; logic cin32, co32;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    full_adder_unit #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Cin(cin1), .Sum(s1), .Cout(co1)
    );
    full_adder_unit #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .Cin(cin4), .Sum(s4), .Cout(co4)
    );
    full_adder_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .Cin(cin8), .Sum(s8), .Cout(co8)
    );
    full_adder_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .A(a32), .B(b32), .Cin(cin32), .Sum(s32), .Cout(co32)
    );

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain unsigned addition, truncated to w+1 bits.
    function automatic logic [64:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic cin, input int w);
        logic [64:0] r;
        logic [64:0] mask;
        r    = 65'(a) + 65'(b) + 65'(cin);
        mask = (65'd1 << (w + 1)) - 65'd1;
        return r & mask;
    endfunction

    // Wait until the currently applied inputs are visible on the outputs.
    task automatic settle();
`ifdef FULL_ADDER_OUTPUT_REG_EN
        @(posedge clk);
`endif
        #1;
    endtask

    logic [2:0] tt_sum_cout [8];
    logic [2:0] abc;

    initial begin
        // Expected {Sum, Cout} for {A,B,Cin} = 0..7, straight from the truth table.
        tt_sum_cout = '{3'b000, 3'b010, 3'b010, 3'b001, 3'b010, 3'b001, 3'b001, 3'b011};
        {a1, b1, cin1}    = '0;
        {a4, b4, cin4}    = '0;
        {a8, b8, cin8}    = '0;
        {a32, b32, cin32} = '0;

`ifdef FULL_ADDER_OUTPUT_REG_EN
        // Reset held: outputs zero regardless of inputs.
        rst_n = 1'b0;
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
        #3;
        check("rst_hold_w8", {56'd0, co8, s8}, 65'd0);
        @(posedge clk); #1;
        check("rst_hold_edge_w8", {56'd0, co8, s8}, 65'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("pre_edge_w8", {56'd0, co8, s8}, 65'd0);
        @(posedge clk); #1;
        check("post_edge_w8", {56'd0, co8, s8}, 65'h100);
`else
        // Combinational build: reset level has no effect.
        rst_n = 1'b0;
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
        #1;
        check("comb_ignores_rst_w8", {56'd0, co8, s8}, 65'h100);
        rst_n = 1'b1;
        a8 = 8'h00; b8 = 8'h00;
        #1;
        check("zeros_w8", {56'd0, co8, s8}, 65'd0);
`endif

        // Exhaustive 1-bit truth table.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            abc = 3'(i);
            {a1, b1, cin1} = abc;
            settle();
            check($sformatf("tt_%03b", abc), {63'd0, s1, co1}, {62'd0, tt_sum_cout[i]});
        end

        // Directed 4-bit patterns.
        @(negedge clk); a4 = 4'hF; b4 = 4'h0; cin4 = 1'b1; settle();
        check("w4_ripple", {60'd0, co4, s4}, {60'd0, 1'b1, 4'h0});
        @(negedge clk); a4 = 4'hA; b4 = 4'h5; cin4 = 1'b0; settle();
        check("w4_a_plus_5", {60'd0, co4, s4}, {60'd0, 1'b0, 4'hF});
        @(negedge clk); a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1; settle();
        check("w4_all_ones", {60'd0, co4, s4}, {60'd0, 1'b1, 4'hF});
        @(negedge clk); a32 = '1; b32 = '1; cin32 = 1'b1; settle();
        check("w32_all_ones", {32'd0, co32, s32}, {32'd0, 1'b1, 32'hFFFF_FFFF});
        @(negedge clk); a32 = '0; b32 = '0; cin32 = 1'b0; settle();
        check("w32_zeros", {32'd0, co32, s32}, 65'd0);

`ifdef FULL_ADDER_OUTPUT_REG_EN
        // Reset mid-stream: async clear between edges, reload after release.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            @(posedge clk); #1;
            check("stream_w8", {56'd0, co8, s8}, model(64'(a8), 64'(b8), cin8, 8));
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clr_w8", {56'd0, co8, s8}, 65'd0);
        @(negedge clk);
        rst_n = 1'b1;
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b1;
        #1;
        check("post_rst_hold_w8", {56'd0, co8, s8}, 65'd0);
        @(posedge clk); #1;
        check("post_rst_load_w8", {56'd0, co8, s8}, 65'h101);
`endif

        // Random regression across widths.
        for (int n = 0; n < 3400; n++) begin
            @(negedge clk);
            a1  = 1'($urandom);  b1  = 1'($urandom);  cin1  = 1'($urandom);
            a4  = 4'($urandom);  b4  = 4'($urandom);  cin4  = 1'($urandom);
            a8  = 8'($urandom);  b8  = 8'($urandom);  cin8  = 1'($urandom);
            a32 = $urandom;      b32 = $urandom;      cin32 = 1'($urandom);
            settle();
            check("rnd_w1",  {63'd0, co1, s1},   model(64'(a1),  64'(b1),  cin1,  1));
            check("rnd_w8",  {56'd0, co8, s8},   model(64'(a8),  64'(b8),  cin8,  8));
            check("rnd_w32", {32'd0, co32, s32}, model(64'(a32), 64'(b32), cin32, 32));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
